// File: rtl/nx_indirect_access_sequencer.sv
// Sequences a single indirect RAM access: write-data register, command
// register, status poll with busy timeout, then a one-cycle response.
module nx_indirect_access_sequencer #(
   parameter int unsigned CMND_ADDRESS    = 0,
   parameter int unsigned DATA_ADDRESS    = 4,
   parameter int unsigned N_REG_ADDR_BITS = 16,
   parameter int unsigned N_DATA_BITS     = 32,
   parameter int unsigned N_ENTRIES       = 1024,
   parameter int unsigned N_TIMEOUT_BITS  = 8,
   parameter logic [3:0]  OP_WRITE        = 4'h1,
   parameter logic [3:0]  OP_READ         = 4'h2,
   localparam int unsigned AW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic                       req_write,
   input  logic [AW-1:0]              req_addr,
   input  logic [N_DATA_BITS-1:0]     req_wdata,
   output logic                       rsp_valid,
   output logic [2:0]                 rsp_status,
   output logic [N_DATA_BITS-1:0]     rsp_rdata,
   output logic [N_REG_ADDR_BITS-1:0] reg_addr,
   output logic                       wr_stb,
   output logic [N_DATA_BITS-1:0]     wr_dat,
   output logic [3:0]                 cmnd_op,
   output logic [AW-1:0]              cmnd_addr,
   input  logic [2:0]                 stat_code,
   input  logic [N_DATA_BITS-1:0]     rd_dat,
   output logic [7:0]                 timeout_cnt
);

   localparam logic [AW:0] ADDR_LAST = (AW+1)'(N_ENTRIES - 1);
   localparam logic [2:0] ST_OK      = 3'd0;
   localparam logic [2:0] ST_BUSY    = 3'd1;
   localparam logic [2:0] ST_RANGE   = 3'd6;
   localparam logic [2:0] ST_TIMEOUT = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DATA,
      S_CMND,
      S_WAIT,
      S_RESP
   } state_t;

   state_t state, state_nxt;

   logic                      wr_q;
   logic [AW-1:0]             addr_q;
   logic [N_DATA_BITS-1:0]    wdata_q;
   logic                      guard_q;
   logic [N_TIMEOUT_BITS-1:0] busy_cnt;
   logic [2:0]                status_q;
   logic [N_DATA_BITS-1:0]    rdata_q;

   logic                      accept;
   logic                      oor;
   logic                      busy;
   logic [N_TIMEOUT_BITS-1:0] busy_inc;
   logic                      expire;
   logic                      polling;

   assign accept   = req_valid & req_ready;
   assign oor      = {1'b0, req_addr} > ADDR_LAST;
   assign busy     = stat_code == ST_BUSY;
   assign busy_inc = busy_cnt + 1'b1;
   assign expire   = busy & (&busy_inc);
   assign polling  = (state == S_WAIT) & ~guard_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (accept) begin
               if (oor)            state_nxt = S_RESP;
               else if (req_write) state_nxt = S_DATA;
               else                state_nxt = S_CMND;
            end
         end
         S_DATA: state_nxt = S_CMND;
         S_CMND: state_nxt = S_WAIT;
         S_WAIT: begin
            if (polling && (!busy || expire)) state_nxt = S_RESP;
         end
         S_RESP: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      wr_stb    = 1'b0;
      reg_addr  = '0;
      wr_dat    = '0;
      cmnd_op   = '0;
      cmnd_addr = '0;
      unique case (state)
         S_IDLE: req_ready = 1'b1;
         S_DATA: begin
            wr_stb   = 1'b1;
            reg_addr = N_REG_ADDR_BITS'(DATA_ADDRESS);
            wr_dat   = wdata_q;
         end
         S_CMND: begin
            wr_stb    = 1'b1;
            reg_addr  = N_REG_ADDR_BITS'(CMND_ADDRESS);
            cmnd_op   = wr_q ? OP_WRITE : OP_READ;
            cmnd_addr = addr_q;
         end
         S_WAIT: begin
            cmnd_op   = wr_q ? OP_WRITE : OP_READ;
            cmnd_addr = addr_q;
         end
         S_RESP: rsp_valid = 1'b1;
         default: ;
      endcase
   end

   // Request capture, status polling and response registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         guard_q     <= 1'b0;
         busy_cnt    <= '0;
         status_q    <= '0;
         rdata_q     <= '0;
         timeout_cnt <= '0;
      end else begin
         if (accept) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (oor) begin
               status_q <= ST_RANGE;
               rdata_q  <= '0;
            end
         end
         if (state == S_CMND) begin
            guard_q  <= 1'b1;
            busy_cnt <= '0;
         end
         if (state == S_WAIT) begin
            guard_q <= 1'b0;
         end
         if (polling) begin
            if (!busy) begin
               status_q <= stat_code;
               rdata_q  <= (!wr_q && stat_code == ST_OK) ? rd_dat : '0;
            end else begin
               busy_cnt <= busy_inc;
               if (expire) begin
                  status_q <= ST_TIMEOUT;
                  rdata_q  <= '0;
                  if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
               end
            end
         end
      end
   end

   assign rsp_status = status_q;
   assign rsp_rdata  = rdata_q;

endmodule
